// File: rtl/outmap_pkg.sv
// Shared definitions for the output-map stager: geometry, state encoding,
// and the byte type carried on the write and window buses.
package outmap_pkg;

  localparam int DEPTH     = 32;               // ring bytes, power of 2
  localparam int WR_BYTES  = 8;                // bytes per PE-side write
  localparam int WIN_BYTES = 16;               // bytes presented downstream
  localparam int PTR_W     = $clog2(DEPTH);    // ring pointer width
  localparam int CNT_W     = PTR_W + 1;        // occupancy width (0..DEPTH)

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } stager_state_e;

  // A write byte count of 0 or above the bus width means a full-width write.
  function automatic logic [3:0] eff_bytes(input logic [3:0] n);
    logic [3:0] r;
    if ((n == 4'd0) || (n > 4'd8)) begin
      r = 4'd8;
    end else begin
      r = n;
    end
    return r;
  endfunction

endpackage

// File: rtl/outmap_stager_if.sv
// Bus bundle between the PE/compressor side (master) and the stager (slave).
interface outmap_stager_if;
  import outmap_pkg::*;

  logic                       layer_start;
  logic                       in_valid;
  byte_t [WR_BYTES-1:0]       in_data;
  logic [3:0]                 in_bytes;
  logic                       in_last;
  logic                       in_ready;
  logic                       start;
  byte_t [WIN_BYTES-1:0]      outmap_data;
  logic [4:0]                 outmap_data_valid_num;
  logic [4:0]                 valid_taken_num;
  logic                       layer_done;
  logic                       take_err;

  modport slave (
    input  layer_start, in_valid, in_data, in_bytes, in_last, valid_taken_num,
    output in_ready, start, outmap_data, outmap_data_valid_num, layer_done, take_err
  );

  modport master (
    output layer_start, in_valid, in_data, in_bytes, in_last, valid_taken_num,
    input  in_ready, start, outmap_data, outmap_data_valid_num, layer_done, take_err
  );

endinterface

// File: rtl/outmap_byte_ring.sv
// Byte ring buffer: storage, read/write pointers, occupancy count and the
// zero-masked window of the oldest buffered bytes.
module outmap_byte_ring
  import outmap_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,      // write accepted this cycle
  input  byte_t [WR_BYTES-1:0]    wr_data,
  input  logic [3:0]              wr_bytes,   // already normalised to 1..8
  input  logic                    take_en,    // consumer side is live
  input  logic [4:0]              take_req,
  output logic [CNT_W-1:0]        count,
  output byte_t [WIN_BYTES-1:0]   win_data,
  output logic [4:0]              win_num,
  output logic                    take_over   // consumer asked for more than shown
);

  byte_t            ring [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] wbytes;
  logic [CNT_W-1:0] take;

  assign wbytes = wr_en ? CNT_W'(wr_bytes) : '0;

  // Window size is the occupancy capped at the window width.
  always_comb begin
    win_num = 5'd0;
    if (count > CNT_W'(WIN_BYTES)) begin
      win_num = 5'(WIN_BYTES);
    end else begin
      win_num = count[4:0];
    end
  end

  // Clamp the consumer's take to what the window shows; flag over-asks.
  always_comb begin
    take      = '0;
    take_over = 1'b0;
    if (take_en) begin
      take_over = (take_req > win_num);
      if (take_over) begin
        take = CNT_W'(win_num);
      end else begin
        take = CNT_W'(take_req);
      end
    end else begin
      take      = '0;
      take_over = 1'b0;
    end
  end

  // Pointers wrap naturally; count cannot overflow because writes are gated
  // on eight free bytes, and cannot underflow because take is clamped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wbytes);
      rd_ptr <= rd_ptr + PTR_W'(take);
      count  <= count + wbytes - take;
    end
  end

  // Storage is left unreset; the window masks anything beyond the count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < WR_BYTES; i++) begin
        if (4'(i) < wr_bytes) begin
          ring[wr_ptr + PTR_W'(i)] <= wr_data[i];
        end
      end
    end
  end

  // Window mux: oldest bytes first, zero beyond the valid count.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < WIN_BYTES; i++) begin
      if (5'(i) < win_num) begin
        win_data[i] = ring[rd_ptr + PTR_W'(i)];
      end else begin
        win_data[i] = 8'h00;
      end
    end
  end

endmodule

// File: rtl/outmap_stager.sv
// Output-map stager: layer FSM around a byte ring that collects variable
// sized PE writes and presents a 16-byte window to the compressor.
module outmap_stager
  import outmap_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  outmap_stager_if.slave bus
);

  stager_state_e     state;
  logic [CNT_W-1:0]  count;
  logic              ready;
  logic              wr_en;
  logic              take_en;
  logic              take_over;
  logic [3:0]        wr_bytes;
  logic              start_pulse;
  logic              done_flag;
  logic              err_flag;

  // Ready only from registered state: FILL with room for a full write.
  assign ready    = (state == ST_FILL) && (count <= CNT_W'(DEPTH - WR_BYTES));
  assign wr_en    = bus.in_valid && ready;
  assign wr_bytes = eff_bytes(bus.in_bytes);
  assign take_en  = (state == ST_FILL) || (state == ST_DRAIN);

  assign bus.in_ready   = ready;
  assign bus.start      = start_pulse;
  assign bus.layer_done = done_flag;
  assign bus.take_err   = err_flag;

  outmap_byte_ring u_ring (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (bus.in_data),
    .wr_bytes  (wr_bytes),
    .take_en   (take_en),
    .take_req  (bus.valid_taken_num),
    .count     (count),
    .win_data  (bus.outmap_data),
    .win_num   (bus.outmap_data_valid_num),
    .take_over (take_over)
  );

  // Layer FSM with registered start/done pulses and the sticky take error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      start_pulse <= 1'b0;
      done_flag   <= 1'b0;
      err_flag    <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      done_flag   <= 1'b0;
      if (take_over) begin
        err_flag <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (bus.layer_start) begin
            state       <= ST_FILL;
            start_pulse <= 1'b1;
          end
        end
        ST_FILL: begin
          if (wr_en && bus.in_last) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (count == '0) begin
            state     <= ST_DONE;
            done_flag <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_outmap_stager.sv
// Directed testbench for outmap_stager with hand-computed expectations.
module tb_outmap_stager;
  import outmap_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  outmap_stager_if bus();

  outmap_stager dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.layer_start     = 1'b0;
    bus.in_valid        = 1'b0;
    bus.in_data         = '0;
    bus.in_bytes        = 4'd0;
    bus.in_last         = 1'b0;
    bus.valid_taken_num = 5'd0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start;
    bus.layer_start = 1'b1;
    tick();
    bus.layer_start = 1'b0;
  endtask

  task automatic write8(input logic [7:0] base, input logic [3:0] n,
                        input logic last, input logic [4:0] take);
    bus.in_valid = 1'b1;
    for (int i = 0; i < WR_BYTES; i++) bus.in_data[i] = base + 8'(i);
    bus.in_bytes        = n;
    bus.in_last         = last;
    bus.valid_taken_num = take;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    vectors++; if (dut.state !== ST_IDLE) begin miscompares++; $display("FAIL rst_state got %0d want %0d", dut.state, ST_IDLE); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got %0b want 0", bus.in_ready); end
    vectors++; if (bus.outmap_data_valid_num !== 5'd0) begin miscompares++; $display("FAIL rst_valid_num got %0d want 0", bus.outmap_data_valid_num); end
    vectors++; if (bus.outmap_data !== '0) begin miscompares++; $display("FAIL rst_data got %0h want 0", bus.outmap_data); end
    vectors++; if ({bus.start, bus.layer_done, bus.take_err} !== 3'b000) begin miscompares++; $display("FAIL rst_flags got %b want 000", {bus.start, bus.layer_done, bus.take_err}); end
    vectors++; if (dut.count !== 6'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", dut.count); end
    rst = 1'b0;
    // a take while IDLE is ignored
    bus.valid_taken_num = 5'd16;
    tick();
    idle_inputs();
    vectors++; if (bus.take_err !== 1'b0) begin miscompares++; $display("FAIL idle_take_err got %0b want 0", bus.take_err); end
  endtask

  task automatic test_start;
    do_reset();
    pulse_start();
    vectors++; if (bus.start !== 1'b1) begin miscompares++; $display("FAIL start_pulse got %0b want 1", bus.start); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL start_in_ready got %0b want 1", bus.in_ready); end
    vectors++; if (bus.outmap_data_valid_num !== 5'd0) begin miscompares++; $display("FAIL start_valid_num got %0d want 0", bus.outmap_data_valid_num); end
    vectors++; if (bus.outmap_data !== '0) begin miscompares++; $display("FAIL start_data got %0h want 0", bus.outmap_data); end
    tick();
    vectors++; if (bus.start !== 1'b0) begin miscompares++; $display("FAIL start_one_cycle got %0b want 0", bus.start); end
  endtask

  task automatic test_fill;
    do_reset();
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      write8(8'(8 * k), 4'd8, 1'b0, 5'd0);
      if (k < 3) begin
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready_%0d got %0b want 1", k, bus.in_ready); end
      end else begin
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_full_ready got %0b want 0", bus.in_ready); end
      end
    end
    vectors++; if (dut.count !== 6'd32) begin miscompares++; $display("FAIL fill_count got %0d want 32", dut.count); end
    vectors++; if (bus.outmap_data_valid_num !== 5'd16) begin miscompares++; $display("FAIL fill_valid_num got %0d want 16", bus.outmap_data_valid_num); end
    for (int i = 0; i < WIN_BYTES; i++) begin
      vectors++; if (bus.outmap_data[i] !== 8'(i)) begin miscompares++; $display("FAIL fill_win_%0d got %0h want %0h", i, bus.outmap_data[i], i); end
    end
    // layer_start outside IDLE is ignored
    bus.layer_start = 1'b1;
    tick();
    bus.layer_start = 1'b0;
    vectors++; if (bus.start !== 1'b0) begin miscompares++; $display("FAIL restart_ignored got %0b want 0", bus.start); end
    vectors++; if (dut.state !== ST_FILL) begin miscompares++; $display("FAIL restart_state got %0d want %0d", dut.state, ST_FILL); end
  endtask

  task automatic test_take_while_write;
    do_reset();
    pulse_start();
    // in_bytes of 0 means a full 8-byte write
    write8(8'h00, 4'd0, 1'b0, 5'd0);
    vectors++; if (bus.outmap_data_valid_num !== 5'd8) begin miscompares++; $display("FAIL zero_bytes_num got %0d want 8", bus.outmap_data_valid_num); end
    vectors++; if (bus.outmap_data[7] !== 8'h07) begin miscompares++; $display("FAIL zero_bytes_b7 got %0h want 07", bus.outmap_data[7]); end
    write8(8'h08, 4'd8, 1'b0, 5'd5);
    vectors++; if (dut.count !== 6'd11) begin miscompares++; $display("FAIL tww_count got %0d want 11", dut.count); end
    vectors++; if (bus.outmap_data_valid_num !== 5'd11) begin miscompares++; $display("FAIL tww_valid_num got %0d want 11", bus.outmap_data_valid_num); end
    vectors++; if (bus.outmap_data[0] !== 8'h05) begin miscompares++; $display("FAIL tww_b0 got %0h want 05", bus.outmap_data[0]); end
    vectors++; if (bus.outmap_data[10] !== 8'h0F) begin miscompares++; $display("FAIL tww_b10 got %0h want 0f", bus.outmap_data[10]); end
    vectors++; if (bus.outmap_data[11] !== 8'h00) begin miscompares++; $display("FAIL tww_mask got %0h want 00", bus.outmap_data[11]); end
    vectors++; if (bus.take_err !== 1'b0) begin miscompares++; $display("FAIL tww_take_err got %0b want 0", bus.take_err); end
  endtask

  task automatic test_wrap;
    do_reset();
    pulse_start();
    for (int k = 0; k < 20; k++) begin
      write8(8'(8 * k), 4'd8, 1'b0, (k == 0) ? 5'd0 : 5'd8);
      vectors++; if (bus.outmap_data_valid_num !== 5'd8) begin miscompares++; $display("FAIL wrap_num_%0d got %0d want 8", k, bus.outmap_data_valid_num); end
      vectors++; if (bus.outmap_data[0] !== 8'(8 * k)) begin miscompares++; $display("FAIL wrap_b0_%0d got %0h want %0h", k, bus.outmap_data[0], 8 * k); end
      vectors++; if (bus.outmap_data[7] !== 8'(8 * k + 7)) begin miscompares++; $display("FAIL wrap_b7_%0d got %0h want %0h", k, bus.outmap_data[7], 8 * k + 7); end
      vectors++; if (bus.outmap_data[8] !== 8'h00) begin miscompares++; $display("FAIL wrap_mask_%0d got %0h want 00", k, bus.outmap_data[8]); end
    end
    vectors++; if (bus.take_err !== 1'b0) begin miscompares++; $display("FAIL wrap_take_err got %0b want 0", bus.take_err); end
  endtask

  task automatic test_last_drain;
    do_reset();
    pulse_start();
    write8(8'h31, 4'd3, 1'b1, 5'd0);
    vectors++; if (dut.state !== ST_DRAIN) begin miscompares++; $display("FAIL last_state got %0d want %0d", dut.state, ST_DRAIN); end
    vectors++; if (bus.outmap_data_valid_num !== 5'd3) begin miscompares++; $display("FAIL last_num got %0d want 3", bus.outmap_data_valid_num); end
    vectors++; if (bus.outmap_data[2] !== 8'h33) begin miscompares++; $display("FAIL last_b2 got %0h want 33", bus.outmap_data[2]); end
    vectors++; if (bus.outmap_data[3] !== 8'h00) begin miscompares++; $display("FAIL last_ignored_b3 got %0h want 00", bus.outmap_data[3]); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL last_ready got %0b want 0", bus.in_ready); end
    bus.valid_taken_num = 5'd16;
    tick();
    idle_inputs();
    vectors++; if (bus.take_err !== 1'b1) begin miscompares++; $display("FAIL over_take_err got %0b want 1", bus.take_err); end
    vectors++; if (dut.count !== 6'd0) begin miscompares++; $display("FAIL over_take_count got %0d want 0", dut.count); end
    vectors++; if (bus.layer_done !== 1'b0) begin miscompares++; $display("FAIL drain_done_early got %0b want 0", bus.layer_done); end
    tick();
    vectors++; if (dut.state !== ST_DONE) begin miscompares++; $display("FAIL done_state got %0d want %0d", dut.state, ST_DONE); end
    vectors++; if (bus.layer_done !== 1'b1) begin miscompares++; $display("FAIL done_pulse got %0b want 1", bus.layer_done); end
    tick();
    vectors++; if (dut.state !== ST_IDLE) begin miscompares++; $display("FAIL back_idle got %0d want %0d", dut.state, ST_IDLE); end
    vectors++; if (bus.layer_done !== 1'b0) begin miscompares++; $display("FAIL done_once got %0b want 0", bus.layer_done); end
    vectors++; if (bus.take_err !== 1'b1) begin miscompares++; $display("FAIL take_err_sticky got %0b want 1", bus.take_err); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    pulse_start();
    write8(8'h40, 4'd8, 1'b0, 5'd0);
    write8(8'h48, 4'd8, 1'b0, 5'd0);
    write8(8'h50, 4'd4, 1'b0, 5'd0);
    vectors++; if (dut.count !== 6'd20) begin miscompares++; $display("FAIL mid_count got %0d want 20", dut.count); end
    vectors++; if (bus.outmap_data_valid_num !== 5'd16) begin miscompares++; $display("FAIL mid_num got %0d want 16", bus.outmap_data_valid_num); end
    rst = 1'b1;
    tick();
    vectors++; if (dut.count !== 6'd0) begin miscompares++; $display("FAIL mid_rst_count got %0d want 0", dut.count); end
    vectors++; if (dut.state !== ST_IDLE) begin miscompares++; $display("FAIL mid_rst_state got %0d want %0d", dut.state, ST_IDLE); end
    vectors++; if (bus.outmap_data !== '0) begin miscompares++; $display("FAIL mid_rst_data got %0h want 0", bus.outmap_data); end
    rst = 1'b0;
    tick();
    vectors++; if (bus.layer_done !== 1'b0) begin miscompares++; $display("FAIL mid_rst_no_done got %0b want 0", bus.layer_done); end
    pulse_start();
    vectors++; if (bus.start !== 1'b1) begin miscompares++; $display("FAIL relayer_start got %0b want 1", bus.start); end
    write8(8'h60, 4'd8, 1'b1, 5'd0);
    vectors++; if (bus.outmap_data[0] !== 8'h60) begin miscompares++; $display("FAIL relayer_b0 got %0h want 60", bus.outmap_data[0]); end
    vectors++; if (dut.state !== ST_DRAIN) begin miscompares++; $display("FAIL relayer_drain got %0d want %0d", dut.state, ST_DRAIN); end
    bus.valid_taken_num = 5'd8;
    tick();
    idle_inputs();
    vectors++; if (bus.outmap_data_valid_num !== 5'd0) begin miscompares++; $display("FAIL relayer_empty got %0d want 0", bus.outmap_data_valid_num); end
    tick();
    vectors++; if (bus.layer_done !== 1'b1) begin miscompares++; $display("FAIL relayer_done got %0b want 1", bus.layer_done); end
    vectors++; if (bus.take_err !== 1'b0) begin miscompares++; $display("FAIL relayer_take_err got %0b want 0", bus.take_err); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_start();
    test_fill();
    test_take_while_write();
    test_wrap();
    test_last_drain();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/outmap_stager.md
OUTMAP_STAGER -- requirements
Module: outmap_stager

Interface
REQ-001 Parameters: DEPTH=32 (ring bytes, power of 2); WR_BYTES=8 (bytes per write); WIN_BYTES=16 (window bytes presented downstream).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 layer_start  in  1  one-cycle pulse; begins a layer.
REQ-005 in_valid  in  1  PE-side write request.
REQ-006 in_data  in  [7:0][7:0]  write bytes; byte 0 is the oldest.
REQ-007 in_bytes  in  4  number of valid bytes in in_data, 1..8; bytes at index in_bytes and above are ignored.
REQ-008 in_last  in  1  marks the final write of the layer; qualified by in_valid && in_ready.
REQ-009 in_ready  out  1  write accepted this cycle when in_valid is also high.
REQ-010 start  out  1  one-cycle pulse to the compressor.
REQ-011 outmap_data  out  [15:0][7:0]  the 16 oldest buffered bytes; byte 0 is the oldest.
REQ-012 outmap_data_valid_num  out  5  number of valid window bytes, 0..16.
REQ-013 valid_taken_num  in  5  bytes the compressor consumes this cycle, 0..16.
REQ-014 layer_done  out  1  one-cycle pulse after the layer fully drains.
REQ-015 take_err  out  1  sticky; set when valid_taken_num exceeds outmap_data_valid_num.

Function
REQ-016 The block SHALL have FSM states IDLE, FILL, DRAIN and DONE.
REQ-017 Transitions: IDLE->FILL on layer_start; FILL->DRAIN on an accepted in_last; DRAIN->DONE when count==0; DONE->IDLE unconditionally.
REQ-018 layer_start outside IDLE SHALL be ignored.
REQ-019 start SHALL pulse for one cycle, in the cycle after the IDLE->FILL edge.
REQ-020 layer_done SHALL be high exactly while in state DONE.
REQ-021 in_ready = (state==FILL) && (DEPTH-count >= 8); it is combinational from registered state only.
REQ-022 On an accepted write, bytes 0..in_bytes-1 SHALL be stored at wr_ptr..wr_ptr+in_bytes-1 mod DEPTH.
REQ-023 On an accepted write, wr_ptr and count SHALL advance by in_bytes.
REQ-024 in_bytes values of 0 or above 8 on an accepted write SHALL be treated as 8 and SHALL NOT set take_err.
REQ-025 outmap_data_valid_num = min(count,16).
REQ-026 outmap_data[i] = ring[rd_ptr+i mod DEPTH] for i < valid_num; otherwise 8'h00.
REQ-027 Window outputs SHALL be combinational from registers: a byte written at edge N is visible after edge N.
REQ-028 take = min(valid_taken_num, valid_num); rd_ptr and count SHALL advance by take at each edge.
REQ-029 take SHALL be honoured in FILL and DRAIN, and ignored (treated as 0) in IDLE and DONE.
REQ-030 Simultaneous write and take: count_next = count + wbytes - take, where wbytes is the accepted write byte count (0 if no write is accepted).
REQ-031 count never exceeds DEPTH and never underflows.
REQ-032 Pointers are log2(DEPTH) bits wide and wrap naturally; count is log2(DEPTH)+1 bits wide.
REQ-033 take_err SHALL be set when valid_taken_num > valid_num in FILL or DRAIN, and is cleared only by rst.
REQ-034 An in_last accepted with count+wbytes-take==0 SHALL pass through DRAIN for one cycle, then DONE.

Reset
REQ-035 rst SHALL force: state=IDLE; rd_ptr=wr_ptr=count=0; start=0; layer_done=0; take_err=0; in_ready=0; valid_num=0; outmap_data all zero.
REQ-036 rst asserted mid-layer SHALL discard all buffered bytes with no layer_done pulse.
REQ-037 Ring storage contents need not be reset; the zero-masking in REQ-026 hides them.

Structure
REQ-038 Shared package outmap_pkg SHALL hold DEPTH, WR_BYTES, WIN_BYTES, the stager_state_e enum and the byte_t typedef.
REQ-039 One sub-module, outmap_byte_ring, SHALL contain storage, pointers, count and the window mux; the FSM stays in outmap_stager.

Verification
REQ-040 Reset then layer_start -> start pulses the next cycle; in_ready=1; valid_num=0; outmap_data=0.
REQ-041 Four 8-byte writes 0x00..0x1F with take=0 -> count=32; in_ready=0 after the 4th write; window=0x00..0x0F; valid_num=16.
REQ-042 Write 8, then take 5 while writing 8 -> count=11; outmap_data[0]=0x05; valid_num=11.
REQ-043 Wrap-around: cycle 20 writes of 8 bytes with take=8 each cycle -> window bytes stay contiguous across the pointer wrap; no take_err.
REQ-044 Write in_bytes=3 with in_last, then take=16 -> valid_num=3; take clamps to 3; take_err=1; DRAIN->DONE; layer_done pulses once; return to IDLE.
REQ-045 rst asserted with 20 bytes buffered in FILL -> the next cycle has count=0, state=IDLE, no layer_done, and a later layer runs normally.
